// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle datapath. It steps each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath enables and the aluop.
module multicycle_control #(
  parameter logic [2:0] ALUOP_AND   = 3'b000,
  parameter logic [2:0] ALUOP_OR    = 3'b001,
  parameter logic [2:0] ALUOP_ADD   = 3'b010,
  parameter logic [2:0] ALUOP_SUB   = 3'b011,
  parameter logic [2:0] ALUOP_RTYPE = 3'b100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] aluop,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_IMM_EXEC  = 4'd11,
    S_IMM_WB    = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] aluop;
  } ctrl_t;

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_op_q;
  logic [5:0] w_op_next;
  ctrl_t      r_ctrl;
  logic       r_in_fetch;
  logic       w_legal;

  // Moore outputs for a given state; the FETCH handshake-qualified strobes are added separately.
  function automatic ctrl_t decodeCtrl(input state_t s, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    c.aluop = ALUOP_AND;
    case (s)
      S_FETCH: begin
        c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.aluop = ALUOP_ADD;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11; c.aluop = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.aluop = ALUOP_ADD;
      end
      S_MEM_READ:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      S_MEM_WB:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEM_WRITE: begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      S_R_EXEC: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b00; c.aluop = ALUOP_RTYPE;
      end
      S_R_WB: begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_BRANCH: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b00; c.aluop = ALUOP_SUB;
        c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
      end
      S_JUMP: begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      S_IMM_EXEC: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        c.aluop = (op == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
      end
      S_IMM_WB: c.reg_write = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  assign w_legal = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_RTYPE) ||
                   (opcode == OP_BEQ) || (opcode == OP_J) || (opcode == OP_ADDI) ||
                   (opcode == OP_ORI);

  assign w_op_next = (r_state == S_DECODE) ? opcode : r_op_q;

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:      w_next = S_FETCH;
      S_FETCH:     w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:     w_next = S_MEM_ADDR;
          OP_RTYPE:         w_next = S_R_EXEC;
          OP_BEQ:           w_next = S_BRANCH;
          OP_J:             w_next = S_JUMP;
          OP_ADDI, OP_ORI:  w_next = S_IMM_EXEC;
          default:          w_next = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  w_next = (r_op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  w_next = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    w_next = S_FETCH;
      S_MEM_WRITE: w_next = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    w_next = S_R_WB;
      S_R_WB:      w_next = S_FETCH;
      S_BRANCH:    w_next = S_FETCH;
      S_JUMP:      w_next = S_FETCH;
      S_IMM_EXEC:  w_next = S_IMM_WB;
      S_IMM_WB:    w_next = S_FETCH;
      default:     w_next = S_IDLE;
    endcase
  end

  // Outputs are registered by decoding the state being entered, so they line up with r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op_q     <= '0;
      r_ctrl     <= '0;
      r_in_fetch <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_op_q     <= w_op_next;
      r_ctrl     <= decodeCtrl(w_next, w_op_next);
      r_in_fetch <= (w_next == S_FETCH);
    end
  end

  assign pc_write      = r_ctrl.pc_write | (r_in_fetch & mem_ready);
  assign ir_write      = r_in_fetch & mem_ready;
  assign pc_write_cond = r_ctrl.pc_write_cond;
  assign i_or_d        = r_ctrl.i_or_d;
  assign mem_read      = r_ctrl.mem_read;
  assign mem_write     = r_ctrl.mem_write;
  assign mem_to_reg    = r_ctrl.mem_to_reg;
  assign reg_dst       = r_ctrl.reg_dst;
  assign reg_write     = r_ctrl.reg_write;
  assign alu_src_a     = r_ctrl.alu_src_a;
  assign alu_src_b     = r_ctrl.alu_src_b;
  assign pc_source     = r_ctrl.pc_source;
  assign aluop         = r_ctrl.aluop;
  assign illegal_op    = (r_state == S_DECODE) && !w_legal;
  assign state         = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a per-cycle vector table followed by
// per-instruction cycle-count sequences with mem_ready held high.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] aluop;
  logic [3:0] state;

  int nChecks = 0;
  int nPass   = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .aluop(aluop), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // Bit order: pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, asa, asb[2], pcs[2], aluop[3], ill
  logic [17:0] obs;
  assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, aluop, illegal_op};

  localparam logic [17:0] O_IDLE    = 18'b0;
  localparam logic [17:0] O_FETCH_R = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,3'b010,1'b0};
  localparam logic [17:0] O_FETCH_S = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,3'b010,1'b0};
  localparam logic [17:0] O_DEC     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,3'b010,1'b0};
  localparam logic [17:0] O_DEC_ILL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,3'b010,1'b1};
  localparam logic [17:0] O_MADDR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,3'b010,1'b0};
  localparam logic [17:0] O_MREAD   = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000,1'b0};
  localparam logic [17:0] O_MWB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,3'b000,1'b0};
  localparam logic [17:0] O_MWR     = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000,1'b0};
  localparam logic [17:0] O_REXEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,3'b100,1'b0};
  localparam logic [17:0] O_RWB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,3'b000,1'b0};
  localparam logic [17:0] O_BR      = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,3'b011,1'b0};
  localparam logic [17:0] O_JMP     = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,3'b000,1'b0};
  localparam logic [17:0] O_IMM_ADD = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,3'b010,1'b0};
  localparam logic [17:0] O_IMM_ORI = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,3'b001,1'b0};
  localparam logic [17:0] O_IMMWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,3'b000,1'b0};

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] JMP = 6'b000010, ADDI = 6'b001000, ORI = 6'b001101, BAD = 6'b111111;

  typedef struct packed {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [17:0] out;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic r, input logic [5:0] o, input logic m,
                        input logic [3:0] s, input logic [17:0] e);
    vec_t v;
    v.rst = r; v.op = o; v.rdy = m; v.st = s; v.out = e;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s #%0d: got %h, expected %h", name, idx, actual, expected);
  endtask

  // One vector per cycle: inputs driven at the falling edge, outputs checked 1ns later.
  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    reset = v.rst; opcode = v.op; mem_ready = v.rdy;
    #1;
    checkOutput("state", idx, {28'd0, state}, {28'd0, v.st});
    checkOutput("outputs", idx, {14'd0, obs}, {14'd0, v.out});
  endtask

  logic [5:0] ccOp[8];
  int         ccLen[8];
  int         n;

  initial begin
    reset = 1'b1; opcode = RT; mem_ready = 1'b1;
    @(posedge clk);

    addVec(1, RT, 1, 0, O_IDLE);     addVec(1, RT, 1, 0, O_IDLE);
    addVec(0, RT, 1, 0, O_IDLE);
    addVec(0, RT, 1, 1, O_FETCH_R);  addVec(0, RT, 1, 2, O_DEC);
    addVec(0, RT, 1, 7, O_REXEC);    addVec(0, RT, 1, 8, O_RWB);
    addVec(0, LW, 0, 1, O_FETCH_S);  addVec(0, LW, 0, 1, O_FETCH_S);
    addVec(0, LW, 0, 1, O_FETCH_S);  addVec(0, LW, 1, 1, O_FETCH_R);
    addVec(0, LW, 1, 2, O_DEC);      addVec(0, RT, 1, 3, O_MADDR);
    addVec(0, RT, 0, 4, O_MREAD);    addVec(0, RT, 0, 4, O_MREAD);
    addVec(0, RT, 1, 4, O_MREAD);    addVec(0, RT, 1, 5, O_MWB);
    addVec(0, ORI, 1, 1, O_FETCH_R); addVec(0, ORI, 1, 2, O_DEC);
    addVec(0, ADDI, 1, 11, O_IMM_ORI); addVec(0, ADDI, 1, 12, O_IMMWB);
    addVec(0, ADDI, 1, 1, O_FETCH_R); addVec(0, ADDI, 1, 2, O_DEC);
    addVec(0, ADDI, 1, 11, O_IMM_ADD); addVec(0, ADDI, 1, 12, O_IMMWB);
    addVec(0, BEQ, 1, 1, O_FETCH_R); addVec(0, BEQ, 1, 2, O_DEC);
    addVec(0, BEQ, 1, 9, O_BR);
    addVec(0, JMP, 1, 1, O_FETCH_R); addVec(0, JMP, 1, 2, O_DEC);
    addVec(0, JMP, 1, 10, O_JMP);
    addVec(0, BAD, 1, 1, O_FETCH_R); addVec(0, BAD, 1, 2, O_DEC_ILL);
    addVec(0, SW, 1, 1, O_FETCH_R);  addVec(0, SW, 1, 2, O_DEC);
    addVec(0, SW, 1, 3, O_MADDR);    addVec(0, SW, 0, 6, O_MWR);
    addVec(1, SW, 0, 6, O_MWR);      addVec(0, SW, 0, 0, O_IDLE);
    addVec(0, SW, 1, 1, O_FETCH_R);  addVec(0, SW, 1, 2, O_DEC);
    addVec(0, SW, 1, 3, O_MADDR);    addVec(0, SW, 1, 6, O_MWR);
    addVec(1, SW, 0, 1, O_FETCH_S);  addVec(1, SW, 0, 0, O_IDLE);
    addVec(0, SW, 1, 0, O_IDLE);     addVec(0, SW, 1, 1, O_FETCH_R);

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    ccOp[0] = LW;   ccLen[0] = 5;  ccOp[1] = SW;  ccLen[1] = 4;
    ccOp[2] = RT;   ccLen[2] = 4;  ccOp[3] = ADDI; ccLen[3] = 4;
    ccOp[4] = ORI;  ccLen[4] = 4;  ccOp[5] = BEQ; ccLen[5] = 3;
    ccOp[6] = JMP;  ccLen[6] = 3;  ccOp[7] = BAD; ccLen[7] = 2;

    // Cycle counts from FETCH back to FETCH with memory always ready.
    @(negedge clk); reset = 1'b1; mem_ready = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    checkOutput("fetchAfterReset", 0, {28'd0, state}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      opcode = ccOp[k];
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (state != 4'd1 && n < 20);
      checkOutput("cycleCount", k, n, ccLen[k]);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle datapath. Sits directly upstream of the ALU control decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives all datapath enables and the 3-bit aluop consumed by the ALU control decoder:
  - aluop[2]=0: ALU control passes aluop straight through as the ALU op.
  - aluop[2]=1: ALU control decodes the R-type func field.
- Stalls on a memory ready handshake.

Parameters:
- ALUOP_AND, 3'b000, direct AND code
- ALUOP_OR, 3'b001, direct OR code
- ALUOP_ADD, 3'b010, direct ADD code
- ALUOP_SUB, 3'b011, direct SUB code
- ALUOP_RTYPE, 3'b100, request func decode

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- opcode  in  6  instruction[31:26] from the instruction register
- mem_ready  in  1  memory has completed the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  writeback data: 0=ALUOut, 1=MDR
- reg_dst  out  1  destination register: 0=rt, 1=rd
- reg_write  out  1  register file write
- alu_src_a  out  1  ALU A input: 0=PC, 1=A
- alu_src_b  out  2  ALU B input: 00=B, 01=4, 10=sign-extended imm, 11=sign-extended imm<<2
- pc_source  out  2  PC source: 00=ALU, 01=ALUOut, 10=jump target
- aluop  out  3  to ALU control
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current state (debug)

Behaviour:
- State register is 4 bits. Encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, IMM_EXEC=11, IMM_WB=12.
- Reset:
  - reset=1 at a clock edge gives state=IDLE and op_q=0, regardless of current state, including mid-instruction or mid-stall.
  - In IDLE all outputs are 0 and aluop=ALUOP_AND.
  - IDLE always goes to FETCH on the next edge.
- Outputs are a Moore decode of state, except ir_write and pc_write in FETCH, which are qualified by mem_ready. Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, aluop=ADD, pc_source=00, ir_write=pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, aluop=ADD.
  - Latches opcode into op_q.
  - Next state by opcode:
    - 100011 (lw) or 101011 (sw): MEM_ADDR
    - 000000: R_EXEC
    - 000100 (beq): BRANCH
    - 000010 (j): JUMP
    - 001000 (addi) or 001101 (ori): IMM_EXEC
    - anything else: FETCH, with illegal_op=1 for this cycle only.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, aluop=ADD. Next state is MEM_READ if op_q=lw, otherwise MEM_WRITE.
- MEM_READ: mem_read=1, i_or_d=1. Stays while mem_ready=0; then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Then FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Stays while mem_ready=0; then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, aluop=RTYPE. Then R_WB.
- R_WB: reg_write=1, reg_dst=1. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, aluop=SUB, pc_write_cond=1, pc_source=01. Then FETCH.
- JUMP: pc_write=1, pc_source=10. Then FETCH.
- IMM_EXEC: alu_src_a=1, alu_src_b=10; aluop=ADD if op_q=addi, OR if op_q=ori. Then IMM_WB.
- IMM_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH.
- Opcode sampling:
  - opcode is sampled only in DECODE; later opcode changes have no effect.
  - Unused state codes 13–15 go to IDLE on the next edge with all outputs 0.
- Cycle counts with mem_ready tied high:
  - lw: 5 cycles
  - R-type, sw, addi, ori: 4 cycles
  - beq, j: 3 cycles
  - illegal opcode: 2 cycles
- mem_write and mem_read are never asserted together.
- reg_write is never asserted in the same cycle as mem_write.

Test Plan:
- Reset: hold reset 2 cycles from any state, release. Expect state=0 with all outputs 0 during reset; state=1 one cycle after release; mem_read=1, aluop=3'b010.
- R-type (opcode=000000, mem_ready=1): expect state sequence 1,2,7,8,1. In state 7 aluop=3'b100 and alu_src_b=00; in state 8 reg_write=1 and reg_dst=1.
- lw with stalls: opcode=100011, mem_ready=0 for 3 cycles in FETCH and 2 cycles in MEM_READ. Expect FETCH held 4 cycles with ir_write=0 until the mem_ready cycle; sequence ...,3,4,4,4,5,1; mem_to_reg=1 in state 5.
- ori/addi: opcode=001101 gives aluop=3'b001 in state 11. Changing opcode to 001000 during state 11 leaves aluop=3'b001. Separately, opcode=001000 gives aluop=3'b010.
- beq and j: opcode=000100 gives state 9 with pc_write_cond=1, pc_source=01, aluop=3'b011. opcode=000010 gives state 10 with pc_write=1, pc_source=10.
- Illegal opcode and reset mid-instruction:
  - opcode=111111: illegal_op high exactly one cycle in DECODE, then FETCH.
  - reset asserted in MEM_WRITE with mem_ready=0: mem_write drops and state=0 on the next edge.
